// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: TX/RX FIFO-buffered controller that sequences words through an SPI master
module spi_burst_ctrl #(
  parameter int BITS = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            spi_start,
  output logic [BITS-1:0] spi_tx_data,
  input  logic            spi_done,
  input  logic [BITS-1:0] spi_rx_data,
  output logic [LW-1:0]   tx_level,
  output logic [LW-1:0]   rx_level,
  output logic            busy,
  output logic            proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2;
  logic [1:0] state;
  logic [BITS-1:0] tx_mem [DEPTH];
  logic [BITS-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_push, tx_pop, rx_push, rx_pop, launch;
  always_comb begin
    tx_ready = tx_level != LW'(DEPTH);
    rx_valid = rx_level != '0;
    tx_push = tx_valid && tx_ready;
    tx_pop = state == START;
    rx_push = state == WAIT && spi_done;
    rx_pop = rx_valid && rx_ready;
    launch = state == IDLE && tx_level != '0 && rx_level != LW'(DEPTH);
    spi_start = state == START;
    busy = state != IDLE;
    rx_data = rx_mem[rx_rp];
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
    if (rx_push) rx_mem[rx_wp] <= spi_rx_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      spi_tx_data <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      tx_level <= '0;
      rx_level <= '0;
      proto_err <= 1'b0;
    end else begin
      tx_wp <= tx_wp + AW'(tx_push);
      tx_rp <= tx_rp + AW'(tx_pop);
      rx_wp <= rx_wp + AW'(rx_push);
      rx_rp <= rx_rp + AW'(rx_pop);
      tx_level <= tx_level + LW'(tx_push) - LW'(tx_pop);
      rx_level <= rx_level + LW'(rx_push) - LW'(rx_pop);
      proto_err <= proto_err || (spi_done && state != WAIT);
      if (launch) spi_tx_data <= tx_mem[tx_rp];
      state <= launch ? START : state == START ? WAIT : rx_push ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: scoreboard bench with an SPI master model for spi_burst_ctrl
module tb_spi_burst_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] tx_data = 0, rx_data, spi_tx_data, spi_rx_data = 0;
  logic tx_valid = 0, tx_ready, rx_valid, rx_ready = 0, spi_start, spi_done;
  logic m_done = 0, inj_done = 0, busy, proto_err;
  logic [2:0] tx_level, rx_level;
  logic [7:0] txq[$], rxq[$];
  logic [7:0] word = 0, exp_w;
  int checks = 0, errors = 0, start_cnt = 0, rx_pops = 0, cyc = 0, last_done = -100;
  int dly = 2, cnt = 0, max_tx = 0, snap;
  bit pending = 0, stall = 0;

  assign spi_done = m_done | inj_done;
  always #5 clk = ~clk;

  spi_burst_ctrl #(.BITS(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .spi_start(spi_start),
    .spi_tx_data(spi_tx_data), .spi_done(spi_done), .spi_rx_data(spi_rx_data),
    .tx_level(tx_level), .rx_level(rx_level), .busy(busy), .proto_err(proto_err)
  );

  // Master model and scoreboard consumer, acting on the falling edge
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      m_done = 0;
      if (rst) pending = 0;
      else begin
        if (pending && !stall) begin
          if (cnt == 0) begin
            m_done = 1;
            spi_rx_data = word;
            rxq.push_back(word);
            pending = 0;
            last_done = cyc;
          end else cnt--;
        end
        if (spi_start) begin
          checks++;
          if (txq.size() == 0) begin
            errors++;
            $display("FAIL start_unexpected spi_tx_data=%h with no word queued", spi_tx_data);
          end else begin
            exp_w = txq.pop_front();
            if (spi_tx_data !== exp_w) begin
              errors++;
              $display("FAIL start_data got %h exp %h", spi_tx_data, exp_w);
            end
          end
          checks++;
          if (cyc - last_done < 2) begin
            errors++;
            $display("FAIL idle_gap got %0d cycles exp >=2", cyc - last_done);
          end
          start_cnt++;
          pending = 1;
          cnt = dly - 1;
          word = spi_tx_data ^ 8'h99;
        end
        if (rx_valid && rx_ready) begin
          checks++;
          rx_pops++;
          if (rxq.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected rx_data=%h with nothing expected", rx_data);
          end else begin
            exp_w = rxq.pop_front();
            if (rx_data !== exp_w) begin
              errors++;
              $display("FAIL rx_data got %h exp %h", rx_data, exp_w);
            end
          end
        end
        if (int'(tx_level) > max_tx) max_tx = int'(tx_level);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1;
    ticks(2);
    rst = 0;
    txq.delete();
    rxq.delete();
    max_tx = 0;
  endtask

  task automatic try_push(input logic [7:0] w);
    tx_valid = 1;
    tx_data = w;
    if (tx_ready) txq.push_back(w);
    tick();
    tx_valid = 0;
  endtask

  task automatic push_wait(input logic [7:0] w);
    int n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL push_timeout tx_ready=%b exp 1", tx_ready);
    end
    try_push(w);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((busy || pending || tx_level != 0 || rx_level != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy || pending || tx_level != 0 || rx_level != 0 || rxq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout busy=%b tx_level=%0d rx_level=%0d rxq=%0d exp all 0",
               busy, tx_level, rx_level, rxq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    ticks(2);
    checks++;
    if ({spi_start, spi_tx_data, tx_ready, tx_level, rx_valid, rx_level, busy, proto_err}
        !== {1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got start=%b txd=%h rdy=%b txl=%0d rxv=%b rxl=%0d busy=%b perr=%b exp 0 00 1 0 0 0 0 0",
               spi_start, spi_tx_data, tx_ready, tx_level, rx_valid, rx_level, busy, proto_err);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    int n = 0;
    dly = 20;
    start_cnt = 0;
    rx_ready = 0;
    try_push(8'hA5);
    checks++;
    if (spi_start !== 1'b0 || tx_level !== 3'd1) begin
      errors++;
      $display("FAIL single_k start=%b tx_level=%0d exp 0 1", spi_start, tx_level);
    end
    tick();
    checks++;
    if (spi_start !== 1'b1 || busy !== 1'b1 || spi_tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_k1 start=%b busy=%b txd=%h exp 1 1 a5", spi_start, busy, spi_tx_data);
    end
    tick();
    checks++;
    if (spi_start !== 1'b0 || tx_level !== 3'd0 || spi_tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_k2 start=%b tx_level=%0d txd=%h exp 0 0 a5", spi_start, tx_level, spi_tx_data);
    end
    while (!rx_valid && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_level !== 3'd1 || busy !== 1'b0 || start_cnt != 1) begin
      errors++;
      $display("FAIL single_done rxv=%b rxd=%h rxl=%0d busy=%b starts=%0d exp 1 3c 1 0 1",
               rx_valid, rx_data, rx_level, busy, start_cnt);
    end
    rx_ready = 1;
    tick();
    rx_ready = 0;
    checks++;
    if (rx_level !== 3'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop rx_level=%0d rx_valid=%b exp 0 0", rx_level, rx_valid);
    end
  endtask

  task automatic test_burst();
    dly = 3;
    start_cnt = 0;
    rx_pops = 0;
    rx_ready = 1;
    for (int i = 1; i <= 6; i++) push_wait(8'(i));
    wait_drain(300);
    checks++;
    if (start_cnt != 6 || rx_pops != 6) begin
      errors++;
      $display("FAIL burst_count starts=%0d pops=%0d exp 6 6", start_cnt, rx_pops);
    end
    rx_ready = 0;
  endtask

  task automatic test_tx_full();
    int n = 0;
    dly = 2;
    stall = 1;
    start_cnt = 0;
    max_tx = 0;
    rx_ready = 0;
    push_wait(8'h10);
    ticks(3);
    for (int i = 1; i <= 4; i++) try_push(8'h10 + 8'(i));
    checks++;
    if (tx_level !== 3'd4 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL txfull_four tx_level=%0d tx_ready=%b exp 4 0", tx_level, tx_ready);
    end
    try_push(8'h15);
    checks++;
    if (tx_level !== 3'd4) begin
      errors++;
      $display("FAIL txfull_fifth tx_level=%0d exp 4", tx_level);
    end
    stall = 0;
    while (!spi_start && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (spi_start !== 1'b1 || tx_ready !== 1'b0 || tx_level !== 3'd4) begin
      errors++;
      $display("FAIL txfull_popcycle start=%b tx_ready=%b tx_level=%0d exp 1 0 4", spi_start, tx_ready, tx_level);
    end
    try_push(8'h77);
    checks++;
    if (tx_level !== 3'd3) begin
      errors++;
      $display("FAIL txfull_pushpop tx_level=%0d exp 3", tx_level);
    end
    rx_ready = 1;
    wait_drain(300);
    checks++;
    if (start_cnt != 5 || max_tx > 4) begin
      errors++;
      $display("FAIL txfull_totals starts=%0d max_level=%0d exp 5 <=4", start_cnt, max_tx);
    end
    rx_ready = 0;
  endtask

  task automatic test_rx_backpressure();
    dly = 2;
    start_cnt = 0;
    rx_ready = 0;
    for (int i = 0; i < 6; i++) push_wait(8'h21 + 8'(i));
    ticks(60);
    checks++;
    if (start_cnt != 4 || busy !== 1'b0 || tx_level !== 3'd2 || rx_level !== 3'd4) begin
      errors++;
      $display("FAIL rxbp_stall starts=%0d busy=%b txl=%0d rxl=%0d exp 4 0 2 4", start_cnt, busy, tx_level, rx_level);
    end
    rx_ready = 1;
    tick();
    rx_ready = 0;
    ticks(30);
    checks++;
    if (start_cnt != 5 || tx_level !== 3'd1 || rx_level !== 3'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rxbp_one starts=%0d txl=%0d rxl=%0d busy=%b exp 5 1 4 0", start_cnt, tx_level, rx_level, busy);
    end
    rx_ready = 1;
    wait_drain(300);
    checks++;
    if (start_cnt != 6) begin
      errors++;
      $display("FAIL rxbp_total starts=%0d exp 6", start_cnt);
    end
    rx_ready = 0;
  endtask

  task automatic test_proto_err();
    snap = start_cnt;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_pre got %b exp 0", proto_err);
    end
    inj_done = 1;
    tick();
    inj_done = 0;
    checks++;
    if (proto_err !== 1'b1 || rx_level !== 3'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL perr_set perr=%b rxl=%0d rxv=%b exp 1 0 0", proto_err, rx_level, rx_valid);
    end
    ticks(5);
    checks++;
    if (proto_err !== 1'b1 || start_cnt != snap) begin
      errors++;
      $display("FAIL perr_sticky perr=%b starts=%0d exp 1 %0d", proto_err, start_cnt, snap);
    end
    do_reset();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_clear got %b exp 0", proto_err);
    end
  endtask

  task automatic test_reset_wait();
    dly = 2;
    stall = 1;
    rx_ready = 0;
    for (int i = 0; i < 3; i++) push_wait(8'h31 + 8'(i));
    ticks(3);
    checks++;
    if (busy !== 1'b1 || tx_level !== 3'd2) begin
      errors++;
      $display("FAIL rstwait_pre busy=%b tx_level=%0d exp 1 2", busy, tx_level);
    end
    rst = 1;
    tick();
    rst = 0;
    txq.delete();
    rxq.delete();
    stall = 0;
    checks++;
    if (busy !== 1'b0 || tx_level !== 3'd0 || rx_level !== 3'd0 || spi_start !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_post busy=%b txl=%0d rxl=%0d start=%b rdy=%b exp 0 0 0 0 1",
               busy, tx_level, rx_level, spi_start, tx_ready);
    end
    snap = start_cnt;
    ticks(2);
    inj_done = 1;
    tick();
    inj_done = 0;
    ticks(3);
    checks++;
    if (proto_err !== 1'b1 || rx_level !== 3'd0 || start_cnt != snap || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_late perr=%b rxl=%0d starts=%0d busy=%b exp 1 0 %0d 0",
               proto_err, rx_level, start_cnt, busy, snap);
    end
    do_reset();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_burst();
    test_tx_full();
    test_rx_backpressure();
    test_proto_err();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
